// File: rtl/sim_pkg.sv
// sim_pkg: shared FSM state encoding and default network dimensions for the run sequencer.
package sim_pkg;
    localparam int DEF_RULES     = 16;
    localparam int DEF_LOG_RULES = 4;
    localparam int DEF_LOG_ITER  = 16;
    typedef enum logic [2:0] {IDLE, CLEAR, INHIBIT, START, WAIT, RESULT} state_t;
endpackage

// File: rtl/run_sequencer.sv
// run_sequencer: drives one simulation run (clear, inhibitor load, start, wait) and returns the captured result.
module run_sequencer
    import sim_pkg::*;
#(
    parameter int RULES     = DEF_RULES,
    parameter int LOG_RULES = DEF_LOG_RULES,
    parameter int LOG_ITER  = DEF_LOG_ITER,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [63:0]          cmd_seed,
    input  logic [RULES-1:0]     cmd_inhib_mask,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RULES-1:0]     res_state,
    output logic [LOG_ITER-1:0]  res_iter,
    output logic                 res_steady,
    output logic                 dp_rst,
    output logic                 dp_start,
    output logic                 dp_ld_inhibitor,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic [63:0]          dp_seed,
    input  logic [RULES-1:0]     dp_network_state,
    input  logic                 dp_steady_state,
    input  logic [LOG_ITER-1:0]  dp_iteration_number,
    output logic                 busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t               state, state_n;
    logic [RULES-1:0]     mask;
    logic [LOG_RULES-1:0] idx;
    logic [CW-1:0]        wcnt;
    logic                 timeout_hit;

    // wcnt holds completed WAIT cycles; the count reaches TIMEOUT at the end of this cycle
    assign timeout_hit      = wcnt == CW'(TIMEOUT - 1);
    assign cmd_ready        = rst && state == IDLE;
    assign res_valid        = rst && state == RESULT;
    assign busy             = state != IDLE;
    assign dp_rst           = !rst || state == CLEAR;
    assign dp_start         = state == START;
    assign dp_ld_inhibitor  = state == INHIBIT && mask[idx];
    assign dp_sel_inhibitor = idx;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = cmd_valid ? CLEAR : IDLE;
            CLEAR:   state_n = INHIBIT;
            INHIBIT: state_n = idx == LOG_RULES'(RULES - 1) ? START : INHIBIT;
            START:   state_n = WAIT;
            WAIT:    state_n = (dp_steady_state || timeout_hit) ? RESULT : WAIT;
            RESULT:  state_n = res_ready ? IDLE : RESULT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mask       <= '0;
            idx        <= '0;
            wcnt       <= '0;
            dp_seed    <= '0;
            res_state  <= '0;
            res_iter   <= '0;
            res_steady <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && cmd_valid) begin
                dp_seed <= cmd_seed;
                mask    <= cmd_inhib_mask;
            end
            idx  <= state == INHIBIT ? idx + 1'b1 : '0;
            wcnt <= state != WAIT ? '0 : wcnt == CW'(TIMEOUT) ? wcnt : wcnt + 1'b1;
            // steady takes precedence over a coincident timeout
            if (state == WAIT && state_n == RESULT) begin
                res_state  <= dp_network_state;
                res_iter   <= dp_iteration_number;
                res_steady <= dp_steady_state;
            end
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scenario tasks with a result scoreboard for run_sequencer (RULES=16, TIMEOUT=100).
module tb_run_sequencer;
    localparam int RULES = 16;
    localparam int TO    = 100;

    typedef struct {
        logic [15:0] st;
        logic [15:0] it;
        logic        sd;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [63:0] cmd_seed = '0;
    logic [15:0] cmd_inhib_mask = '0;
    logic        res_valid, res_ready = 1'b0;
    logic [15:0] res_state, res_iter;
    logic        res_steady;
    logic        dp_rst, dp_start, dp_ld_inhibitor;
    logic [3:0]  dp_sel_inhibitor;
    logic [63:0] dp_seed;
    logic [15:0] dp_network_state = '0;
    logic        dp_steady_state = 1'b0;
    logic [15:0] dp_iteration_number = '0;
    logic        busy;
    int          checks = 0, failures = 0;
    exp_t        sb[$];

    run_sequencer #(.RULES(RULES), .LOG_RULES(4), .LOG_ITER(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed),
        .cmd_inhib_mask(cmd_inhib_mask), .res_valid(res_valid), .res_ready(res_ready),
        .res_state(res_state), .res_iter(res_iter), .res_steady(res_steady), .dp_rst(dp_rst),
        .dp_start(dp_start), .dp_ld_inhibitor(dp_ld_inhibitor), .dp_sel_inhibitor(dp_sel_inhibitor),
        .dp_seed(dp_seed), .dp_network_state(dp_network_state), .dp_steady_state(dp_steady_state),
        .dp_iteration_number(dp_iteration_number), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [63:0] seed, input logic [15:0] mask);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL accept_ready got=%b exp=1", cmd_ready); end
        cmd_seed = seed; cmd_inhib_mask = mask; cmd_valid = 1'b1;
        step;
        cmd_valid = 1'b0; cmd_seed = '0; cmd_inhib_mask = '0;
        checks++;
        if ({dp_rst, dp_start, dp_ld_inhibitor, busy, cmd_ready} !== 5'b10010) begin
            failures++; $display("FAIL clear_cycle got=%b exp=10010", {dp_rst, dp_start, dp_ld_inhibitor, busy, cmd_ready});
        end
        checks++;
        if (dp_seed !== seed) begin failures++; $display("FAIL seed got=%h exp=%h", dp_seed, seed); end
        for (int k = 0; k < RULES; k++) begin
            step;
            checks++;
            if (dp_sel_inhibitor !== 4'(k) || dp_ld_inhibitor !== mask[k] || dp_start !== 1'b0 || dp_rst !== 1'b0) begin
                failures++;
                $display("FAIL inhibit_%0d got sel=%0d ld=%b start=%b rst=%b exp sel=%0d ld=%b start=0 rst=0",
                         k, dp_sel_inhibitor, dp_ld_inhibitor, dp_start, dp_rst, k, mask[k]);
            end
        end
        step;
        checks++;
        if (dp_start !== 1'b1 || dp_ld_inhibitor !== 1'b0 || dp_rst !== 1'b0) begin
            failures++; $display("FAIL start_cycle got start=%b ld=%b rst=%b exp 1/0/0", dp_start, dp_ld_inhibitor, dp_rst);
        end
        step;
    endtask

    // Called in WAIT cycle 1; at_cycle = WAIT cycle in which steady rises (0 = never)
    task automatic finish_wait(input int at_cycle, input logic [15:0] st, input logic [15:0] it,
                               input logic sd, input int exp_waits);
        int n = 1;
        dp_network_state = st; dp_iteration_number = it;
        sb.push_back('{st: st, it: it, sd: sd});
        while (res_valid !== 1'b1 && n <= TO + 5) begin
            dp_steady_state = (n == at_cycle);
            step;
            n++;
        end
        dp_steady_state = 1'b0;
        dp_network_state = ~st; dp_iteration_number = it + 16'd1;
        checks++;
        if (n - 1 !== exp_waits || res_valid !== 1'b1) begin
            failures++; $display("FAIL wait_cycles got=%0d valid=%b exp=%0d valid=1", n - 1, res_valid, exp_waits);
        end
    endtask

    task automatic collect(input int hold);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL scoreboard_empty got=0 exp=1"); return; end
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (res_valid !== 1'b1 || res_state !== e.st || res_iter !== e.it || res_steady !== e.sd || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL result_hold%0d got v=%b st=%h it=%0d sd=%b rdy=%b exp v=1 st=%h it=%0d sd=%b rdy=0",
                         h, res_valid, res_state, res_iter, res_steady, cmd_ready, e.st, e.it, e.sd);
            end
            if (h < hold) step;
        end
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++; $display("FAIL return_idle got rdy=%b busy=%b v=%b exp 1/0/0", cmd_ready, busy, res_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step; step;
        checks++;
        if ({dp_rst, cmd_ready, res_valid, busy, dp_start, dp_ld_inhibitor} !== 6'b100000 ||
            res_state !== '0 || res_iter !== '0 || res_steady !== 1'b0 || dp_seed !== '0) begin
            failures++; $display("FAIL reset_state got ctl=%b st=%h it=%h sd=%b seed=%h exp ctl=100000 all zero",
                                 {dp_rst, cmd_ready, res_valid, busy, dp_start, dp_ld_inhibitor}, res_state, res_iter, res_steady, dp_seed);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dp_rst !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release got dp_rst=%b rdy=%b exp 0/1", dp_rst, cmd_ready);
        end
    endtask

    task automatic test_inhibit_steady;
        start_run(64'h1, 16'h0005);
        finish_wait(5, 16'hBEEF, 16'd42, 1'b1, 5);
        collect(0);
    endtask

    task automatic test_timeout;
        start_run(64'hDEAD_BEEF_0123_4567, 16'hFFFF);
        finish_wait(0, 16'h1234, 16'd77, 1'b0, TO);
        collect(0);
    endtask

    task automatic test_tie;
        start_run(64'h55AA_55AA_55AA_55AA, 16'h8001);
        finish_wait(TO, 16'hCAFE, 16'd99, 1'b1, TO);
        collect(0);
    endtask

    task automatic test_backpressure;
        start_run(64'h0F0F_0000_FFFF_1234, 16'hA5A5);
        finish_wait(3, 16'h5A5A, 16'd7, 1'b1, 3);
        collect(10);
    endtask

    task automatic test_back_to_back;
        start_run(64'h2, 16'h0000);
        finish_wait(1, 16'h0001, 16'd1, 1'b1, 1);
        collect(0);
        start_run(64'h3, 16'h7FFE);
        finish_wait(2, 16'h8000, 16'd65535, 1'b1, 2);
        collect(0);
    endtask

    task automatic test_mid_reset;
        bit seen = 0;
        cmd_seed = 64'hFFFF; cmd_inhib_mask = 16'hFFFF; cmd_valid = 1'b1;
        step;
        cmd_valid = 1'b0;
        repeat (5) step;
        rst = 1'b0; cmd_valid = 1'b1;
        #1;
        checks++;
        if (dp_rst !== 1'b1 || cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
            failures++; $display("FAIL midreset_comb got dp_rst=%b rdy=%b v=%b exp 1/0/0", dp_rst, cmd_ready, res_valid);
        end
        step;
        checks++;
        if (busy !== 1'b0 || dp_start !== 1'b0 || dp_ld_inhibitor !== 1'b0 || dp_seed !== '0 ||
            res_state !== '0 || res_iter !== '0 || res_steady !== 1'b0 || dp_rst !== 1'b1) begin
            failures++; $display("FAIL midreset_state got busy=%b start=%b ld=%b seed=%h dp_rst=%b exp 0/0/0/0/1",
                                 busy, dp_start, dp_ld_inhibitor, dp_seed, dp_rst);
        end
        cmd_valid = 1'b0; rst = 1'b1; dp_steady_state = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_idle got rdy=%b busy=%b exp 1/0", cmd_ready, busy);
        end
        for (int i = 0; i < 150; i++) begin
            step;
            if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        dp_steady_state = 1'b0;
        checks++;
        if (seen) begin failures++; $display("FAIL midreset_no_result got=1 exp=0"); end
    endtask

    initial begin
        test_reset;
        test_inhibit_steady;
        test_timeout;
        test_tie;
        test_backpressure;
        test_back_to_back;
        test_mid_reset;
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RULES, 16, network rule count.
- LOG_RULES, 4, width of a rule index.
- LOG_ITER, 16, width of the iteration count.
- TIMEOUT, 65535, maximum WAIT cycles before a run is abandoned.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is on the rising edge.
- rst, in, 1, reset; synchronous and active-low.
- cmd_valid, in, 1, run request valid.
- cmd_ready, out, 1, sequencer can accept a run.
- cmd_seed, in, 64, RNG seed for the run.
- cmd_inhib_mask, in, RULES, rules to inhibit; bit i set inhibits rule i.
- res_valid, out, 1, result valid.
- res_ready, in, 1, result consumed.
- res_state, out, RULES, captured network state.
- res_iter, out, LOG_ITER, captured iteration number.
- res_steady, out, 1, 1 = converged, 0 = timed out.
- dp_rst, out, 1, active-high reset to the simulation datapath.
- dp_start, out, 1, start pulse to the datapath.
- dp_ld_inhibitor, out, 1, inhibitor load strobe.
- dp_sel_inhibitor, out, LOG_RULES, inhibitor index.
- dp_seed, out, 64, seed to the datapath.
- dp_network_state, in, RULES, datapath state.
- dp_steady_state, in, 1, datapath steady flag (level).
- dp_iteration_number, in, LOG_ITER, datapath iteration count.
- busy, out, 1, high in every state except IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, CLEAR, INHIBIT, START, WAIT and RESULT.
REQ-004 cmd_ready SHALL be high only in IDLE; a run is accepted on the edge where cmd_valid and cmd_ready are both high.
REQ-005 On accept, the block SHALL register cmd_seed into dp_seed (held until the next accept) and cmd_inhib_mask into an internal mask, then go to CLEAR.
REQ-006 CLEAR SHALL last exactly 1 cycle, with dp_rst high, then go to INHIBIT.
REQ-007 INHIBIT SHALL last exactly RULES cycles, visiting index k = 0..RULES-1 in order.
- dp_sel_inhibitor = k in each visited cycle.
- dp_ld_inhibitor = mask[k].
- Timing SHALL be the same whatever the mask value.
REQ-008 START SHALL last 1 cycle with dp_start high, then go to WAIT.
REQ-009 Timing SHALL be fixed relative to the accept edge at cycle N.
- CLEAR in cycle N+1.
- INHIBIT in cycles N+2 to N+RULES+1.
- START in cycle N+RULES+2.
- First WAIT cycle is N+RULES+3.
REQ-010 A wait counter SHALL clear on entry to WAIT and increment by 1 each WAIT cycle, saturating at TIMEOUT.
REQ-011 In WAIT, if dp_steady_state is high, the block SHALL go to RESULT.
- It SHALL capture dp_network_state into res_state and dp_iteration_number into res_iter in that same cycle.
- It SHALL set res_steady = 1.
REQ-012 In WAIT, if the counter equals TIMEOUT and dp_steady_state is low, the block SHALL capture the same values with res_steady = 0 and go to RESULT.
REQ-013 If steady and timeout occur in the same cycle, steady SHALL win (res_steady = 1).
REQ-014 In RESULT, res_valid SHALL be high and res_* SHALL be held stable until res_valid and res_ready are both high; the block then returns to IDLE.
REQ-015 res_valid SHALL NOT depend combinationally on res_ready.
REQ-016 dp_start, dp_ld_inhibitor and dp_rst SHALL be low in every state other than the ones named above for them.

Reset
REQ-017 While rst is low, the following SHALL hold:
- dp_rst is high, driven combinationally from rst.
- cmd_ready and res_valid are low.
- No command is accepted.
REQ-018 At the next edge with rst low, the block SHALL enter IDLE with these values:
- All res_* outputs, dp_seed, the internal mask and the wait counter are 0.
- dp_start and dp_ld_inhibitor are 0.
- busy is 0.
REQ-019 A reset mid-run (any state) SHALL abandon the run with no result produced.

Structure
REQ-020 A shared package sim_pkg SHALL hold the FSM state enum and the default RULES/LOG_RULES/LOG_ITER constants.
REQ-021 The block SHALL be a single module with no sub-modules; the index counter and the wait counter are local registers.

Verification
REQ-022 The bench SHALL cover at least these scenarios, with RULES=16 and TIMEOUT=100 unless stated.
- Mask 16'h0005, seed 64'h1: dp_ld_inhibitor high only in the INHIBIT cycles with sel=0 and sel=2; dp_start high in cycle N+18.
- Steady high in WAIT cycle 5 with state 16'hBEEF and iter 42: res_state=16'hBEEF, res_iter=42, res_steady=1, res_valid high from the next cycle.
- Steady never asserted: res_steady=0 after exactly 100 WAIT cycles, res_valid high.
- Steady asserted in the same cycle the counter reaches TIMEOUT: res_steady=1.
- res_ready held low for 10 cycles: res_* stable, cmd_ready low; res_ready=1 gives IDLE and cmd_ready=1 on the next cycle.
- rst low during INHIBIT: the next cycle is IDLE with all outputs 0, dp_rst high during reset, and no res_valid ever.
